// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressed, big-endian 4-lane storage behind a valid/ready
// handshake with a fixed access latency. Define DATA_MEM_ALIGN_CHECK_EN to flag misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
`ifdef DATA_MEM_ALIGN_CHECK_EN
  output logic        mem_misaligned,
`endif
  output logic        mem_resp_valid
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [7:0] MIS_PATTERN [0:3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic [AW-1:0] addr_reg;
  logic          we_reg;
  logic [7:0]    wdata_reg [0:3];
  logic [AW-1:0] lane_addr [0:3];
  logic          misaligned;
  logic          commit;

  logic [7:0] mem_array [0:DEPTH_BYTES-1];

  // Address bits above the array size are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:AW];

  // Lane i addresses latched_addr + i; the AW-bit add wraps at the top of the array.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi] = addr_reg + AW'(gi);
    end
  endgenerate

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = (addr_reg[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign commit = (state_reg == ST_ACCESS) && we_reg && !misaligned;

  // Storage is never reset; only a transaction that reaches ACCESS writes it.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        mem_array[lane_addr[i]] <= wdata_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      mem_ready      <= 1'b1;
      mem_resp_valid <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      mem_misaligned <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
        wdata_reg[i]    <= '0;
        mem_data_out[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mem_req) begin
            addr_reg  <= mem_addr[AW-1:0];
            we_reg    <= mem_write_en;
            for (int i = 0; i < 4; i++) begin
              wdata_reg[i] <= mem_data_in[i];
            end
            cnt_reg   <= 4'(LATENCY - 1);
            mem_ready <= 1'b0;
            state_reg <= (LATENCY > 1) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_reg <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Writes leave mem_data_out holding the last read data.
          if (!we_reg) begin
            for (int i = 0; i < 4; i++) begin
              mem_data_out[i] <= misaligned ? MIS_PATTERN[i] : mem_array[lane_addr[i]];
            end
          end
          mem_resp_valid <= 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          mem_misaligned <= misaligned;
`endif
          state_reg      <= ST_RESP;
        end
        default: begin
          mem_resp_valid <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          mem_misaligned <= 1'b0;
`endif
          mem_ready      <= 1'b1;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: timing, big-endian lanes, wrap-around, reset abort
// and, with DATA_MEM_ALIGN_CHECK_EN defined, misaligned-access handling.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 4096;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [7:0]  mem_data_in  [0:3];
  logic [7:0]  mem_data_out [0:3];
  logic        mem_resp_valid;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic        mem_misaligned;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] last_rd    = 32'h0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
`ifdef DATA_MEM_ALIGN_CHECK_EN
    .mem_misaligned (mem_misaligned),
`endif
    .mem_resp_valid (mem_resp_valid)
  );

  function automatic logic [31:0] dout_word();
    return {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes(input logic [31:0] w);
    mem_data_in[0] = w[31:24];
    mem_data_in[1] = w[23:16];
    mem_data_in[2] = w[15:8];
    mem_data_in[3] = w[7:0];
  endtask

  // One full request: waits for ready, checks response timing, data and strobe shape.
  task automatic xact(input string name, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic [31:0] exp_rd);
    int          n;
    logic        exp_mis;
    logic [31:0] exp_out;
    exp_mis = ALIGN && (addr[1:0] != 2'b00);
    exp_out = we ? last_rd : (exp_mis ? 32'hDEAD_BEEF : exp_rd);
    n = 0;
    @(negedge clk);
    while (!mem_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, "_ready"}, 32'(mem_ready), 32'd1);
    mem_addr     = addr;
    mem_write_en = we;
    drive_lanes(wdata);
    mem_req      = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the request fields: the responder must use its latched copies.
    mem_req      = 1'b0;
    mem_addr     = ~addr;
    mem_write_en = ~we;
    drive_lanes(~wdata);
    repeat (LAT - 1) @(posedge clk);
    #1;
    check_eq({name, "_early"}, 32'(mem_resp_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq({name, "_valid"}, 32'(mem_resp_valid), 32'd1);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check_eq({name, "_mis"}, 32'(mem_misaligned), 32'(exp_mis));
`endif
    check_eq({name, "_data"}, dout_word(), exp_out);
    @(posedge clk);
    #1;
    check_eq({name, "_done"}, {30'd0, mem_resp_valid, mem_ready}, 32'd1);
    last_rd = exp_out;
    $display("xact %-10s %s addr=%h wdata=%h data_out=%h", name, we ? "WR" : "RD",
             addr, wdata, dout_word());
  endtask

  initial begin
    int acc;
    int n;
    rst_b        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    drive_lanes(32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(mem_ready), 32'd1);
    check_eq("rst_valid", 32'(mem_resp_valid), 32'd0);
    check_eq("rst_data", dout_word(), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    $display("xact reset     released");

    // Basic write / read and big-endian lane order.
    xact("wr10", 32'h10, 1'b1, 32'h1122_3344, 32'h0);
    xact("wr14", 32'h14, 1'b1, 32'h5566_7788, 32'h0);
    xact("rd10", 32'h10, 1'b0, 32'h0, 32'h1122_3344);
    xact("rd12", 32'h12, 1'b0, 32'h0, 32'h3344_5566);

    // Continuous request: one acceptance per LAT+2 cycles.
    xact("wr20", 32'h20, 1'b1, 32'hC0C1_C2C3, 32'h0);
    acc = 0;
    @(negedge clk);
    mem_addr     = 32'h20;
    mem_write_en = 1'b0;
    mem_req      = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (mem_ready) acc++;
      @(negedge clk);
    end
    mem_req = 1'b0;
    check_eq("hold_accepts", 32'(acc), 32'd4);
    check_eq("hold_data", dout_word(), 32'hC0C1_C2C3);
    last_rd = 32'hC0C1_C2C3;
    $display("xact hold      RD addr=00000020 accepts=%0d data_out=%h", acc, dout_word());

    // Wrap-around at the top of the array; upper address bits ignored.
    xact("wr000", 32'h000, 1'b1, 32'hB1B2_B3B4, 32'h0);
    xact("wrffc", 32'hFFC, 1'b1, 32'hC1C2_C3C4, 32'h0);
    xact("wrffe", 32'hFFE, 1'b1, 32'hA1A2_A3A4, 32'h0);
    xact("rd1000", 32'h1000, 1'b0, 32'h0, ALIGN ? 32'hB1B2_B3B4 : 32'hA3A4_B3B4);
    xact("rdffc", 32'hFFC, 1'b0, 32'h0, ALIGN ? 32'hC1C2_C3C4 : 32'hC1C2_A1A2);

    // Reset during WAIT aborts an uncommitted write.
    xact("wr40", 32'h40, 1'b1, 32'h0102_0304, 32'h0);
    @(negedge clk);
    mem_addr     = 32'h40;
    mem_write_en = 1'b1;
    drive_lanes(32'hFFFF_FFFF);
    mem_req      = 1'b1;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    check_eq("abort_busy", 32'(mem_ready), 32'd0);
    #1;
    rst_b = 1'b0;
    #1;
    check_eq("abort_ready_async", 32'(mem_ready), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mem_resp_valid) n++;
    end
    check_eq("abort_no_resp", 32'(n), 32'd0);
    check_eq("abort_data", dout_word(), 32'h0);
    last_rd = 32'h0;
    $display("xact abort     WR addr=00000040 resp_count=%0d", n);
    xact("rd40", 32'h40, 1'b0, 32'h0, 32'h0102_0304);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    xact("wr44", 32'h44, 1'b1, 32'h0506_0708, 32'h0);
    xact("rd41", 32'h41, 1'b0, 32'h0, 32'hDEAD_BEEF);
    xact("wr43", 32'h43, 1'b1, 32'hFFFF_FFFF, 32'h0);
    xact("rd40b", 32'h40, 1'b0, 32'h0, 32'h0102_0304);
    xact("rd44", 32'h44, 1'b0, 32'h0, 32'h0506_0708);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: receives mem_addr, mem_data_in[0:3] and mem_write_en, and returns mem_data_out[0:3].
- Byte-addressed, four byte lanes, big-endian: lane 0 maps to the lowest address and is the MSB of the core's 32-bit word.
- Adds a valid/ready handshake and a programmable access latency, so multi-cycle memory can be modelled behind the core.

Parameters:
- DEPTH_BYTES, 4096: storage size in bytes; power of two, at least 4.
- LATENCY, 2: cycles from request acceptance to response; range 1..15.

Ports:
- clk  input  1  clock, rising-edge.
- rst_b  input  1  asynchronous, active-low reset.
- mem_req  input  1  request valid.
- mem_ready  output  1  responder can accept a request this cycle.
- mem_addr  input  32  byte address of lane 0.
- mem_write_en  input  1  1 = write, 0 = read; sampled with mem_req.
- mem_data_in  input  4x8 ([7:0] [0:3])  write data; lane i goes to address mem_addr+i.
- mem_data_out  output  4x8 ([7:0] [0:3])  read data; lane i comes from address mem_addr+i.
- mem_resp_valid  output  1  one-cycle response strobe.

Behaviour:
- Reset is asynchronous, active-low, one clock (clk); exactly as already decided.
- Reset values: state = IDLE, mem_ready = 1, mem_resp_valid = 0, mem_data_out = 0 on all lanes, latency counter = 0.
- Storage array is not cleared by reset.
- States:
  - IDLE: mem_ready = 1. On mem_req, latch addr, write data and we; load cnt = LATENCY-1. Go to WAIT if cnt != 0, otherwise go to ACCESS.
  - WAIT: mem_ready = 0. Decrement cnt; go to ACCESS when cnt reaches 0.
  - ACCESS: single clock edge. For a write, commit the 4 latched lanes to the array. For a read, load mem_data_out from the array. Go to RESP.
  - RESP: mem_resp_valid = 1 and mem_ready = 0 for exactly one cycle, then return to IDLE.
- Timing:
  - An acceptance edge (mem_req & mem_ready) is followed by mem_resp_valid high in cycle LATENCY+1 after it.
  - Throughput is one request per LATENCY+2 cycles.
- mem_req while mem_ready = 0 is ignored; it is not queued. The requester must hold mem_req until it sees mem_ready.
- Inputs changing after acceptance have no effect; all request fields are latched.
- Write responses: mem_data_out holds its previous value; only mem_resp_valid pulses.
- mem_data_out keeps the last read data until the next read's ACCESS edge.
- Address mapping: byte index = (latched_addr + i) mod DEPTH_BYTES for lane i. Upper address bits are ignored, and an access crossing the top of the array wraps to byte 0.
- Reset mid-transaction aborts it:
  - A write not yet at its ACCESS edge is never committed.
  - A write already committed stays in the array.
  - No response is issued for an aborted transaction.

Optional Feature:
- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port mem_misaligned (1 bit, reset 0).
  - A request with latched addr[1:0] != 0 still walks IDLE -> WAIT -> ACCESS -> RESP.
  - At ACCESS, no write is committed and reads load mem_data_out = {8'hDE, 8'hAD, 8'hBE, 8'hEF}.
  - mem_misaligned pulses together with mem_resp_valid.
- Undefined: no port is added; misaligned accesses proceed byte-wise with wrap-around as above.

Test Plan:
- Reset then idle: mem_ready = 1, mem_resp_valid = 0, mem_data_out = 0. Assert rst_b low mid-WAIT -> mem_ready = 1 immediately (asynchronous), and no mem_resp_valid afterwards.
- LATENCY = 2: write addr 0x10, data {11,22,33,44}; then read 0x10 -> resp_valid 3 cycles after each acceptance; read lanes {11,22,33,44}. Read 0x12 -> {33,44,xx,xx}, where xx is the prior content at 0x14/0x15.
- Hold mem_req high continuously with addr 0x20 -> exactly one acceptance per 4 cycles. Changing mem_addr during WAIT leaves the response data from the latched address.
- DEPTH_BYTES = 4096: write 0x0FFE with {A1,A2,A3,A4} -> bytes 0x0FFE = A1, 0x0FFF = A2, 0x000 = A3, 0x001 = A4. Read 0x1000 returns the contents of 0x000.
- Write 0x40 = {01,02,03,04}. Start a write of {FF,FF,FF,FF} to 0x40 and pulse rst_b low during WAIT. Read 0x40 -> {01,02,03,04}.
- With DATA_MEM_ALIGN_CHECK_EN: read 0x41 -> {DE,AD,BE,EF} with mem_misaligned = 1 in the resp cycle. Write 0x43 -> no byte at 0x43..0x46 changes.
